nx_srfram_hw_arbiter: RTL and testbench

Shares the hardware port of the SRFRAM indirect-access wrapper among N_REQ hardware clients using round-robin arbitration. After reset, and on request, it runs a sequenced initialisation walk that writes INIT_DATA to every entry. It honours the wrapper's hw_yield by forcing bounded idle cycles, so the software indirect-access path cannot starve. It sits between client datapaths and the wrapper's hw_* port.

---
 rtl/nx_srfram_hw_arbiter_pkg.sv | 15 +
 rtl/nx_srfram_hw_arbiter_if.sv | 36 +++
 rtl/nx_srfram_hw_arbiter_rr_arb.sv | 30 +++
 rtl/nx_srfram_hw_arbiter.sv | 128 ++++++++++++
 tb/tb_nx_srfram_hw_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/nx_srfram_hw_arbiter_pkg.sv
// Shared types and helpers for the SRFRAM hardware-port arbiter.
package nx_srfram_hw_arbiter_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        YIELD = 2'd2
    } srfram_arb_state_e;

    // Round-robin successor of idx within 0..n-1.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/nx_srfram_hw_arbiter_if.sv
// Client request/response bus plus the wrapper hw_* port, as seen by the arbiter.
// master: the arbiter (owns the wrapper port, answers the clients).
// slave:  the environment (client datapaths and the indirect-access wrapper).
interface nx_srfram_hw_arbiter_if #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned N_DATA_BITS = 32,
    parameter int unsigned AW          = 10
) ();
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0]             req_we;
    logic [N_REQ*AW-1:0]          req_addr;
    logic [N_REQ*N_DATA_BITS-1:0] req_wdat;
    logic [N_REQ-1:0]             rsp_valid;
    logic [N_DATA_BITS-1:0]       rsp_dat;
    logic                         hw_cs;
    logic                         hw_we;
    logic                         hw_re;
    logic [AW-1:0]                hw_raddr;
    logic [AW-1:0]                hw_waddr;
    logic [N_DATA_BITS-1:0]       hw_din;
    logic [N_DATA_BITS-1:0]       hw_dout;
    logic                         hw_yield;

    modport master (
        input  req_valid, req_we, req_addr, req_wdat, hw_dout, hw_yield,
        output req_ready, rsp_valid, rsp_dat,
        output hw_cs, hw_we, hw_re, hw_raddr, hw_waddr, hw_din
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdat, hw_dout, hw_yield,
        input  req_ready, rsp_valid, rsp_dat,
        input  hw_cs, hw_we, hw_re, hw_raddr, hw_waddr, hw_din
    );
endinterface

// File: rtl/nx_srfram_hw_arbiter_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr, modulo N_REQ.
module nx_srfram_hw_arbiter_rr_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             any
);
    // Scan candidates in priority order starting at ptr; keep the first hit.
    always_comb begin
        int unsigned cand;
        logic [N_REQ-1:0] shifted;
        cand    = 0;
        shifted = '0;
        idx     = '0;
        any     = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand    = (32'(ptr) + k) % N_REQ;
            shifted = req >> cand;
            if (!any && shifted[0]) begin
                any = 1'b1;
                idx = PW'(cand);
            end
        end
        grant = any ? (N_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/nx_srfram_hw_arbiter.sv
// Round-robin sharing of the SRFRAM wrapper hw port, with an init walk and
// bounded bursts so pending software accesses get idle cycles.
module nx_srfram_hw_arbiter
    import nx_srfram_hw_arbiter_pkg::*;
#(
    parameter int unsigned           N_REQ         = 4,
    parameter int unsigned           N_DATA_BITS   = 32,
    parameter int unsigned           N_ENTRIES     = 1024,
    parameter int unsigned           MAX_HW_BURST  = 8,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [N_DATA_BITS-1:0] INIT_DATA    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_start,
    output logic                   init_busy,
    output logic                   init_done,
    nx_srfram_hw_arbiter_if.master bus
);
    localparam int unsigned AW = $clog2(N_ENTRIES);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BW = $clog2(MAX_HW_BURST + 1);

    srfram_arb_state_e state_q, ret_q, state_after;
    logic [AW-1:0]     init_addr_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [BW-1:0]     burst_cnt_q;
    logic [N_REQ-1:0]  rsp_valid_q;

    logic [N_REQ-1:0]       gnt;
    logic [PW-1:0]          gidx;
    logic                   gany;
    logic                   grant_en;
    logic                   last_init;
    logic                   yield_hit;
    logic                   g_we;
    logic [AW-1:0]          g_addr;
    logic [N_DATA_BITS-1:0] g_wdat;

    nx_srfram_hw_arbiter_rr_arb #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (gnt),
        .idx   (gidx),
        .any   (gany)
    );

    assign grant_en  = !rst && (state_q == RUN) && !init_start && gany;
    // Full compare so a non-power-of-2 depth ends the walk at N_ENTRIES-1.
    assign last_init = (init_addr_q == AW'(N_ENTRIES - 1));
    assign yield_hit = bus.hw_cs && bus.hw_yield && (burst_cnt_q == BW'(MAX_HW_BURST - 1));
    assign g_we      = bus.req_we[gidx];
    assign g_addr    = AW'(bus.req_addr >> (32'(gidx) * AW));
    assign g_wdat    = N_DATA_BITS'(bus.req_wdat >> (32'(gidx) * N_DATA_BITS));

    // Drive the wrapper port and client grants from the current state; idle in reset.
    always_comb begin
        bus.req_ready = '0;
        bus.hw_cs     = 1'b0;
        bus.hw_we     = 1'b0;
        bus.hw_re     = 1'b0;
        bus.hw_raddr  = '0;
        bus.hw_waddr  = '0;
        bus.hw_din    = '0;
        if (!rst && state_q == INIT) begin
            bus.hw_cs    = 1'b1;
            bus.hw_we    = 1'b1;
            bus.hw_raddr = init_addr_q;
            bus.hw_waddr = init_addr_q;
            bus.hw_din   = INIT_DATA;
        end else if (grant_en) begin
            bus.req_ready = gnt;
            bus.hw_cs     = 1'b1;
            bus.hw_we     = g_we;
            bus.hw_re     = !g_we;
            bus.hw_raddr  = g_addr;
            bus.hw_waddr  = g_addr;
            bus.hw_din    = g_wdat;
        end
    end

    assign init_busy     = (state_q == INIT);
    assign init_done     = !rst && (state_q == INIT) && last_init;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = bus.hw_dout;

    // Where the FSM goes next when no forced yield intervenes.
    always_comb begin
        state_after = state_q;
        case (state_q)
            INIT:    if (last_init) state_after = RUN;
            RUN:     if (init_start) state_after = INIT;
            YIELD:   state_after = ret_q;
            default: state_after = RUN;
        endcase
    end

    // State, init walker, round-robin pointer, burst counter and response pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_ON_RESET ? INIT : RUN;
            ret_q       <= RUN;
            init_addr_q <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= bus.hw_re ? bus.req_ready : '0;
            // Cleared on the yield trigger so the YIELD cycle sees zero.
            burst_cnt_q <= (bus.hw_cs && bus.hw_yield && !yield_hit) ? burst_cnt_q + 1'b1 : '0;
            if (state_q == INIT) begin
                init_addr_q <= last_init ? '0 : init_addr_q + 1'b1;
            end
            if (grant_en) begin
                rr_ptr_q <= PW'(rr_wrap_inc(32'(gidx), N_REQ));
            end
            if (yield_hit) begin
                state_q <= YIELD;
                ret_q   <= state_after;
            end else begin
                state_q <= state_after;
            end
        end
    end
endmodule

// File: tb/tb_nx_srfram_hw_arbiter.sv
// Directed bench for nx_srfram_hw_arbiter with a small RAM model for the wrapper.
module tb_nx_srfram_hw_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned NE    = 16;
    localparam int unsigned AW    = 4;

    logic clk = 1'b0;
    logic rst;
    logic init_start;
    logic init_busy;
    logic init_done;

    int checks   = 0;
    int failures = 0;

    nx_srfram_hw_arbiter_if #(.N_REQ(N_REQ), .N_DATA_BITS(DW), .AW(AW)) bus ();

    nx_srfram_hw_arbiter #(
        .N_REQ         (N_REQ),
        .N_DATA_BITS   (DW),
        .N_ENTRIES     (NE),
        .MAX_HW_BURST  (8),
        .INIT_ON_RESET (1'b1),
        .INIT_DATA     (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Fixed per-client targets: c0 addr 2, c1 addr 5, c2 addr 4, c3 addr 5.
    assign bus.req_addr = {4'd5, 4'd4, 4'd5, 4'd2};
    assign bus.req_wdat = {32'h0000_0033, 32'h0000_0022, 32'hA5A5_0001, 32'h0000_0011};

    // Wrapper RAM model: write commits at the edge, read data one cycle later.
    bit [DW-1:0] mem [NE];
    always @(posedge clk) begin
        if (bus.hw_cs && bus.hw_we) mem[bus.hw_waddr] <= bus.hw_din;
        if (bus.hw_cs && bus.hw_re) bus.hw_dout <= mem[bus.hw_raddr];
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [3:0]  rdy;
        logic        hwe;
        logic        hre;
        logic [3:0]  addr;
        logic [31:0] din;
        logic [3:0]  rsp;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mkv(input logic [3:0] valid, input logic [3:0] we,
                                 input logic [3:0] rdy, input logic hwe, input logic hre,
                                 input logic [3:0] addr, input logic [31:0] din,
                                 input logic [3:0] rsp, input logic [31:0] rdat);
        vec_t v;
        v.valid = valid; v.we = we; v.rdy = rdy; v.hwe = hwe; v.hre = hre;
        v.addr = addr; v.din = din; v.rsp = rsp; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full 16-entry init walk starting at the current cycle.
    task automatic check_walk(input string tag);
        for (int i = 0; i < NE; i++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d] cs", tag, i), 64'(bus.hw_cs), 64'd1);
            chk($sformatf("%s[%0d] we", tag, i), 64'(bus.hw_we), 64'd1);
            chk($sformatf("%s[%0d] re", tag, i), 64'(bus.hw_re), 64'd0);
            chk($sformatf("%s[%0d] waddr", tag, i), 64'(bus.hw_waddr), 64'(i));
            chk($sformatf("%s[%0d] raddr", tag, i), 64'(bus.hw_raddr), 64'(i));
            chk($sformatf("%s[%0d] din", tag, i), 64'(bus.hw_din), 64'd0);
            chk($sformatf("%s[%0d] ready", tag, i), 64'(bus.req_ready), 64'd0);
            chk($sformatf("%s[%0d] busy", tag, i), 64'(init_busy), 64'd1);
            chk($sformatf("%s[%0d] done", tag, i), 64'(init_done), 64'(i == NE - 1));
            next_cycle();
        end
    endtask

    initial begin
        rst           = 1'b1;
        init_start    = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.hw_yield  = 1'b0;
        bus.hw_dout   = '0;

        // valid, we -> ready, hw_we, hw_re, addr, din, rsp_valid, rsp_dat
        vecs[0]  = mkv(4'b0101, 4'b0101, 4'b0001, 1, 0, 4'd2, 32'h11, 4'b0000, 32'h0);
        vecs[1]  = mkv(4'b0101, 4'b0101, 4'b0100, 1, 0, 4'd4, 32'h22, 4'b0000, 32'h0);
        vecs[2]  = mkv(4'b0101, 4'b0101, 4'b0001, 1, 0, 4'd2, 32'h11, 4'b0000, 32'h0);
        vecs[3]  = mkv(4'b0101, 4'b0101, 4'b0100, 1, 0, 4'd4, 32'h22, 4'b0000, 32'h0);
        vecs[4]  = mkv(4'b0010, 4'b0010, 4'b0010, 1, 0, 4'd5, 32'hA5A5_0001, 4'b0000, 32'h0);
        vecs[5]  = mkv(4'b1000, 4'b0000, 4'b1000, 0, 1, 4'd5, 32'h33, 4'b0000, 32'h0);
        vecs[6]  = mkv(4'b0000, 4'b0000, 4'b0000, 0, 0, 4'd0, 32'h0, 4'b1000, 32'hA5A5_0001);
        vecs[7]  = mkv(4'b1111, 4'b0000, 4'b0001, 0, 1, 4'd2, 32'h11, 4'b0000, 32'h0);
        vecs[8]  = mkv(4'b1111, 4'b0000, 4'b0010, 0, 1, 4'd5, 32'hA5A5_0001, 4'b0001, 32'h11);
        vecs[9]  = mkv(4'b1111, 4'b0000, 4'b0100, 0, 1, 4'd4, 32'h22, 4'b0010, 32'hA5A5_0001);
        vecs[10] = mkv(4'b1010, 4'b0000, 4'b1000, 0, 1, 4'd5, 32'h33, 4'b0100, 32'h22);
        vecs[11] = mkv(4'b1010, 4'b1000, 4'b0010, 0, 1, 4'd5, 32'hA5A5_0001, 4'b1000,
                       32'hA5A5_0001);
        vecs[12] = mkv(4'b1000, 4'b1000, 4'b1000, 1, 0, 4'd5, 32'h33, 4'b0010, 32'hA5A5_0001);
        vecs[13] = mkv(4'b0010, 4'b0000, 4'b0010, 0, 1, 4'd5, 32'hA5A5_0001, 4'b0000, 32'h0);
        vecs[14] = mkv(4'b0000, 4'b0000, 4'b0000, 0, 0, 4'd0, 32'h0, 4'b0010, 32'h33);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst cs", 64'(bus.hw_cs), 64'd0);
        chk("rst we", 64'(bus.hw_we), 64'd0);
        chk("rst busy", 64'(init_busy), 64'd1);
        chk("rst done", 64'(init_done), 64'd0);
        chk("rst ready", 64'(bus.req_ready), 64'd0);
        chk("rst rsp", 64'(bus.rsp_valid), 64'd0);
        next_cycle();
        rst           = 1'b0;
        bus.req_valid = 4'b0101;
        bus.req_we    = 4'b0101;
        check_walk("init");

        // RUN vectors
        for (int i = 0; i < 15; i++) begin
            bus.req_valid = vecs[i].valid;
            bus.req_we    = vecs[i].we;
            @(negedge clk);
            chk($sformatf("v%0d ready", i), 64'(bus.req_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d cs", i), 64'(bus.hw_cs), 64'(vecs[i].rdy != 4'b0000));
            chk($sformatf("v%0d hw_we", i), 64'(bus.hw_we), 64'(vecs[i].hwe));
            chk($sformatf("v%0d hw_re", i), 64'(bus.hw_re), 64'(vecs[i].hre));
            chk($sformatf("v%0d waddr", i), 64'(bus.hw_waddr), 64'(vecs[i].addr));
            chk($sformatf("v%0d raddr", i), 64'(bus.hw_raddr), 64'(vecs[i].addr));
            chk($sformatf("v%0d din", i), 64'(bus.hw_din), 64'(vecs[i].din));
            chk($sformatf("v%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].rsp));
            chk($sformatf("v%0d busy", i), 64'(init_busy), 64'd0);
            if (vecs[i].rsp != 4'b0000) begin
                chk($sformatf("v%0d rsp_dat", i), 64'(bus.rsp_dat), 64'(vecs[i].rdat));
            end
            next_cycle();
        end

        // Forced yield: 8 busy cycles then one idle, repeating
        bus.req_valid = 4'b1111;
        bus.req_we    = 4'b0000;
        bus.hw_yield  = 1'b1;
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            chk($sformatf("yield[%0d] cs", k), 64'(bus.hw_cs), 64'((k % 9) != 8));
            chk($sformatf("yield[%0d] grants", k), 64'($countones(bus.req_ready)),
                64'((k % 9) != 8));
            next_cycle();
        end
        bus.hw_yield  = 1'b0;
        bus.req_valid = 4'b0000;
        next_cycle();

        // Re-init while client 0 has a read in flight
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("pre-init ready", 64'(bus.req_ready), 64'b0001);
        chk("pre-init re", 64'(bus.hw_re), 64'd1);
        next_cycle();
        init_start = 1'b1;
        @(negedge clk);
        chk("init_start ready", 64'(bus.req_ready), 64'd0);
        chk("init_start cs", 64'(bus.hw_cs), 64'd0);
        chk("init_start rsp_valid", 64'(bus.rsp_valid), 64'b0001);
        chk("init_start rsp_dat", 64'(bus.rsp_dat), 64'h11);
        next_cycle();
        init_start = 1'b0;
        check_walk("reinit");
        @(negedge clk);
        chk("post-init ready", 64'(bus.req_ready), 64'b0001);
        chk("post-init raddr", 64'(bus.hw_raddr), 64'd2);
        next_cycle();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("post-init rsp_valid", 64'(bus.rsp_valid), 64'b0001);
        chk("post-init rsp_dat", 64'(bus.rsp_dat), 64'h0);
        next_cycle();

        // Reset in the middle of a walk, at address 7
        init_start = 1'b1;
        next_cycle();
        init_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("partial[%0d] waddr", i), 64'(bus.hw_waddr), 64'(i));
            chk($sformatf("partial[%0d] done", i), 64'(init_done), 64'd0);
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst cs", 64'(bus.hw_cs), 64'd0);
        chk("midrst done", 64'(init_done), 64'd0);
        chk("midrst busy", 64'(init_busy), 64'd1);
        next_cycle();
        rst = 1'b0;
        check_walk("rstwalk");
        @(negedge clk);
        chk("after rstwalk busy", 64'(init_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
